// File: rtl/ram_word_seq.sv
// ram_word_seq: moves one 256-bit operand between a register and a
// 32-bit-wide RAM with a registered read port, one word per clock.
// Writes take 8 access cycles, reads take 8 access cycles plus one drain
// cycle to collect the last word, and every operation ends with a
// one-cycle done pulse.
module ram_word_seq #(
    parameter int WORDS = 8,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [WORDS*32-1:0]   wr_data,
    output logic [WORDS*32-1:0]   rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         ram_addr,
    output logic                  ram_wr_en,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [AW-1:0]            r_cnt;
    logic [WORDS-1:0][31:0]   r_wbuf;
    logic [WORDS-1:0][31:0]   r_rd;
    logic                     w_accept;

    assign rd_data = r_rd;

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and RAM-side outputs, decoded purely from state and counter
    // so that reset forces every output low without waiting for a clock.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        ram_addr  = '0;
        ram_wr_en = 1'b0;
        ram_wdata = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = op ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                ram_addr  = r_cnt;
                ram_wr_en = 1'b1;
                ram_wdata = r_wbuf[r_cnt];
                if (r_cnt == LAST) w_next = S_DONE;
            end
            S_READ: begin
                busy     = 1'b1;
                ram_addr = r_cnt;
                if (r_cnt == LAST) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Word counter: cleared on acceptance, advances once per access cycle;
    // the wrap from LAST back to 0 coincides with leaving WRITE/READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == S_WRITE || r_state == S_READ) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand latch so wr_data may change once the request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbuf <= '0;
        end else if (w_accept) begin
            r_wbuf <= wr_data;
        end
    end

    // Read assembly: RAM data lags the address by one cycle, so the word
    // addressed in the previous cycle is stored; the last word lands in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd <= '0;
        end else if (r_state == S_READ && r_cnt != '0) begin
            r_rd[r_cnt - 1'b1] <= ram_rdata;
        end else if (r_state == S_DRAIN) begin
            r_rd[LAST] <= ram_rdata;
        end
    end

endmodule
